// File: rtl/sccb_pkg.sv
// Shared types and helpers for the SCCB master: FSM states, the quarter-bit
// phase encoding, the latched request and the quarter-period derivation.
package sccb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_TX_BYTE,
    ST_TX_X,
    ST_RX_BYTE,
    ST_RX_NA,
    ST_STOP,
    ST_GAP
  } state_e;

  // Each bus slot is four quarters; SIOC is low in Q0/Q1 and high in Q2/Q3.
  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } quarter_e;

  // Request fields captured on accept and held for the whole transaction.
  typedef struct packed {
    logic        rw;
    logic [6:0]  id;
    logic [15:0] sub_addr;
    logic [7:0]  wr_data;
  } req_t;

  // System clocks per quarter of an SIOC bit period.
  function automatic int unsigned calc_qtr(input int unsigned clk_freq,
                                           input int unsigned sioc_freq);
    return clk_freq / (sioc_freq * 4);
  endfunction

endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-bit tick generator: a one-cycle tick every QTR clocks. Held at zero
// while i_clr is high so each transaction starts on a clean quarter boundary.
module sccb_tick_gen #(
  parameter int unsigned QTR = 250
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick,
  output logic o_first
);

  localparam int unsigned CW = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [CW-1:0] LAST = CW'(QTR - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: wrap at the end of a quarter, hold at zero while cleared.
  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (i_clr || cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  // Count register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick  = !i_clr && (cnt_q == LAST);
  assign o_first = !i_clr && (cnt_q == '0);

endmodule

// File: rtl/sccb_master.sv
// SCCB master: 3-phase write or 2-phase write + 2-phase read transactions
// on SIOC/SIOD, paced by quarter-bit ticks. Bus pins and status are registered.
module sccb_master
  import sccb_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned SIOC_FREQ = 100_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_rw,
  input  logic [6:0]  i_id,
  input  logic [15:0] i_sub_addr,
  input  logic [7:0]  i_wr_data,
  output logic [7:0]  o_rd_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_sioc,
  output logic        o_siod_out,
  output logic        o_siod_oe,
  input  logic        i_siod_in
);

  localparam int unsigned QTR = calc_qtr(CLK_FREQ, SIOC_FREQ);

  state_e     state_q, state_d;
  quarter_e   qtr_q, qtr_d;
  logic [2:0] bit_q, bit_d;
  logic [1:0] byte_q, byte_d;
  logic       phase2_q, phase2_d;
  req_t       req_q, req_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic [1:0] sync_q, sync_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       sioc_q, sioc_d;
  logic       siod_q, siod_d;
  logic       oe_q, oe_d;

  logic       tick, first, slot_end, last_tx, sioc_low;
  logic [7:0] tx_byte;

  sccb_tick_gen #(.QTR(QTR)) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (state_q == ST_IDLE),
    .o_tick (tick),
    .o_first(first)
  );

  assign slot_end = tick && (qtr_q == Q3);
  // Write sends id, addr hi, addr lo, data; the read's first phase stops after addr lo.
  assign last_tx  = (byte_q == (req_q.rw ? 2'd2 : 2'd3));

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: slots advance only at the end of Q3.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (i_start) state_d = ST_START;
      ST_START:   if (slot_end) state_d = ST_TX_BYTE;
      ST_TX_BYTE: if (slot_end && bit_q == 3'd7) state_d = ST_TX_X;
      ST_TX_X: begin
        if (slot_end) begin
          if (phase2_q)     state_d = ST_RX_BYTE;
          else if (last_tx) state_d = ST_STOP;
          else              state_d = ST_TX_BYTE;
        end
      end
      ST_RX_BYTE: if (slot_end && bit_q == 3'd7) state_d = ST_RX_NA;
      ST_RX_NA:   if (slot_end) state_d = ST_STOP;
      ST_STOP:    if (slot_end) state_d = (req_q.rw && !phase2_q) ? ST_GAP : ST_IDLE;
      ST_GAP:     if (slot_end) state_d = ST_START;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Counters, request latch, SIOD synchronizer and read shift register.
  always_comb begin
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    phase2_d  = phase2_q;
    req_d     = req_q;
    rx_sh_d   = rx_sh_q;
    rd_data_d = rd_data_q;
    sync_d    = {sync_q[0], i_siod_in};
    if (state_q == ST_IDLE) begin
      qtr_d    = Q0;
      bit_d    = '0;
      byte_d   = '0;
      phase2_d = 1'b0;
      if (i_start) begin
        req_d = '{rw: i_rw, id: i_id, sub_addr: i_sub_addr, wr_data: i_wr_data};
      end
    end else begin
      if (tick) begin
        qtr_d = quarter_e'(qtr_q + 2'd1);
      end
      if (slot_end) begin
        case (state_q)
          ST_TX_BYTE, ST_RX_BYTE: bit_d = bit_q + 3'd1;
          ST_TX_X:                if (!phase2_q && !last_tx) byte_d = byte_q + 2'd1;
          ST_GAP:                 phase2_d = 1'b1;
          default:                ;
        endcase
      end
      // Sample in the first clock of Q2, right at the SIOC rising edge.
      if (state_q == ST_RX_BYTE && qtr_q == Q2 && first) begin
        rx_sh_d = {rx_sh_q[6:0], sync_q[1]};
      end
      if (slot_end && state_q == ST_STOP && req_q.rw && phase2_q) begin
        rd_data_d = rx_sh_q;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      qtr_q     <= Q0;
      bit_q     <= '0;
      byte_q    <= '0;
      phase2_q  <= 1'b0;
      req_q     <= '0;
      rx_sh_q   <= '0;
      rd_data_q <= '0;
      sync_q    <= 2'b11;
    end else begin
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      phase2_q  <= phase2_d;
      req_q     <= req_d;
      rx_sh_q   <= rx_sh_d;
      rd_data_q <= rd_data_d;
      sync_q    <= sync_d;
    end
  end

  // Byte to transmit for the slot being entered.
  always_comb begin
    tx_byte = {req_q.id, 1'b0};
    if (phase2_d) begin
      tx_byte = {req_q.id, 1'b1};
    end else begin
      case (byte_d)
        2'd1:    tx_byte = req_q.sub_addr[15:8];
        2'd2:    tx_byte = req_q.sub_addr[7:0];
        2'd3:    tx_byte = req_q.wr_data;
        default: ;
      endcase
    end
  end

  // Output logic: pin values decoded from the upcoming state/quarter so the
  // registered pins line up with the slot the FSM has just entered.
  always_comb begin
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    sioc_low = (qtr_d == Q0) || (qtr_d == Q1);
    sioc_d   = 1'b1;
    siod_d   = 1'b1;
    oe_d     = 1'b1;
    case (state_d)
      ST_START: siod_d = sioc_low;
      ST_TX_BYTE: begin
        sioc_d = !sioc_low;
        siod_d = tx_byte[3'd7 - bit_d];
      end
      ST_TX_X, ST_RX_BYTE: begin
        sioc_d = !sioc_low;
        oe_d   = 1'b0;
      end
      ST_RX_NA: sioc_d = !sioc_low;
      ST_STOP: begin
        sioc_d = !sioc_low;
        siod_d = (qtr_d == Q3);
      end
      default: ;
    endcase
  end

  // Registered bus pins and status.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sioc_q <= 1'b1;
      siod_q <= 1'b1;
      oe_q   <= 1'b1;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      sioc_q <= sioc_d;
      siod_q <= siod_d;
      oe_q   <= oe_d;
    end
  end

  assign o_rd_data  = rd_data_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_sioc     = sioc_q;
  assign o_siod_out = siod_q;
  assign o_siod_oe  = oe_q;

endmodule

// File: tb/tb_sccb_master.sv
// Testbench for sccb_master at SIOC_FREQ=400 kHz (QTR=62). A bus monitor
// decodes START/STOP/bytes from the pins and a responder plays the slave's
// read byte; results are compared with a token-level transaction model.
module tb_sccb_master;

  localparam int QTR       = 62;
  localparam int SLOT      = 4 * QTR;
  localparam int START_TOK = 256;
  localparam int STOP_TOK  = 257;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic        i_rw;
  logic [6:0]  i_id;
  logic [15:0] i_sub_addr;
  logic [7:0]  i_wr_data;
  logic [7:0]  o_rd_data;
  logic        o_busy, o_done, o_sioc, o_siod_out, o_siod_oe;

  logic        slave_en, slave_bit;
  logic [7:0]  slave_byte;
  wire         siod_bus = o_siod_oe ? o_siod_out : (slave_en ? slave_bit : 1'b1);

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  sccb_master #(.CLK_FREQ(100_000_000), .SIOC_FREQ(400_000)) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_rw      (i_rw),
    .i_id      (i_id),
    .i_sub_addr(i_sub_addr),
    .i_wr_data (i_wr_data),
    .o_rd_data (o_rd_data),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_sioc    (o_sioc),
    .o_siod_out(o_siod_out),
    .o_siod_oe (o_siod_oe),
    .i_siod_in (siod_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- bus monitor and slave responder ----------------
  logic       mon_en = 1'b0;
  logic       sioc_prev, siod_prev;
  int         rise_cnt, t_rise1, period_meas;
  logic [7:0] cur;
  logic       rd_mode;
  int         got_q[$];

  always @(negedge clk) begin
    if (!mon_en) begin
      rise_cnt    = 0;
      rd_mode     = 1'b0;
      slave_en    = 1'b0;
      slave_bit   = 1'b1;
      period_meas = 0;
      got_q.delete();
    end else if (sioc_prev && o_sioc && siod_prev != siod_bus) begin
      // SIOD moving while SIOC is high is a START (falling) or STOP (rising).
      got_q.push_back(siod_bus ? STOP_TOK : START_TOK);
      rise_cnt = 0;
      if (!siod_bus) begin
        rd_mode  = 1'b0;
        slave_en = 1'b0;
      end
    end else if (!sioc_prev && o_sioc) begin
      rise_cnt++;
      if (rise_cnt == 1) t_rise1 = cyc;
      if (rise_cnt == 2 && period_meas == 0) period_meas = cyc - t_rise1;
      if ((rise_cnt - 1) % 9 < 8) begin
        cur = {cur[6:0], siod_bus};
        if (rise_cnt == 8) rd_mode = siod_bus;
      end else begin
        if ((rise_cnt - 1) / 9 == 1 && rd_mode) begin
          check("na_bit_oe", o_siod_oe, 1);
          check("na_bit_val", o_siod_out, 1);
        end else begin
          check("ninth_bit_oe", o_siod_oe, 0);
        end
        got_q.push_back(int'(cur));
      end
    end else if (sioc_prev && !o_sioc) begin
      // Slave drives read bits while SIOC is low after the read id's ninth bit.
      if (rd_mode && rise_cnt >= 9 && rise_cnt <= 16) begin
        slave_en  = 1'b1;
        slave_bit = slave_byte[16 - rise_cnt];
      end else begin
        slave_en = 1'b0;
      end
    end
    sioc_prev = o_sioc;
    siod_prev = siod_bus;
  end

  // ---------------- transaction driver + model ----------------
  logic [7:0] exp_rd = 8'h00;

  task automatic run_txn(input logic rw, input logic [6:0] id, input logic [15:0] addr,
                         input logic [7:0] wd, input logic [7:0] sb,
                         input bit poke, input int rst_at, input string nm);
    int exp_q[$];
    int lat;
    int exp_lat;
    bit seen_done;
    exp_q.push_back(START_TOK);
    exp_q.push_back(int'({id, 1'b0}));
    exp_q.push_back(int'(addr[15:8]));
    exp_q.push_back(int'(addr[7:0]));
    if (rw) begin
      exp_q.push_back(STOP_TOK);
      exp_q.push_back(START_TOK);
      exp_q.push_back(int'({id, 1'b1}));
      exp_q.push_back(int'(sb));
    end else begin
      exp_q.push_back(int'(wd));
    end
    exp_q.push_back(STOP_TOK);
    exp_lat = (rw ? 50 : 38) * SLOT;

    slave_byte = sb;
    mon_en = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    i_start = 1'b1; i_rw = rw; i_id = id; i_sub_addr = addr; i_wr_data = wd;
    @(negedge clk);
    i_start = 1'b0;
    lat = 0;
    seen_done = 1'b0;
    while (!seen_done && lat < 60 * SLOT) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check({nm, "_busy_after_accept"}, o_busy, 1);
      if (poke && lat == 1000) begin
        i_start = 1'b1; i_rw = ~rw; i_id = ~id; i_sub_addr = ~addr; i_wr_data = ~wd;
      end
      if (poke && lat == 1001) i_start = 1'b0;
      if (lat == rst_at) begin
        mon_en = 1'b0;
        i_rst  = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        exp_rd = 8'h00;
        check({nm, "_rst_sioc"}, o_sioc, 1);
        check({nm, "_rst_siod"}, o_siod_out, 1);
        check({nm, "_rst_oe"}, o_siod_oe, 1);
        check({nm, "_rst_busy"}, o_busy, 0);
        check({nm, "_rst_rd_data"}, o_rd_data, 0);
        for (int i = 0; i < 2 * SLOT; i++) begin
          @(negedge clk);
          if (o_done) seen_done = 1'b1;
        end
        check({nm, "_rst_no_done"}, seen_done, 0);
        return;
      end
      if (o_done) seen_done = 1'b1;
    end
    check({nm, "_done_seen"}, seen_done, 1);
    check({nm, "_latency"}, lat, exp_lat);
    if (rw) exp_rd = sb;
    check({nm, "_rd_data"}, o_rd_data, exp_rd);
    @(negedge clk);
    check({nm, "_done_pulse"}, o_done, 0);
    check({nm, "_busy_idle"}, o_busy, 0);
    check({nm, "_idle_bus"}, {o_sioc, o_siod_out, o_siod_oe}, 3'b111);
    check({nm, "_token_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({nm, "_token"}, got_q[i], exp_q[i]);
    end
    // A second done would betray a start accepted while busy.
    seen_done = 1'b0;
    for (int i = 0; i < 2 * SLOT; i++) begin
      @(negedge clk);
      if (o_done) seen_done = 1'b1;
    end
    check({nm, "_single_done"}, seen_done, 0);
    mon_en = 1'b0;
  endtask

  initial begin
    logic       r_rw;
    logic [6:0] r_id;
    logic [15:0] r_addr;
    logic [7:0] r_wd, r_sb;
    i_rst = 1'b1; i_start = 1'b0; i_rw = 1'b0; i_id = '0; i_sub_addr = '0; i_wr_data = '0;
    slave_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_sioc", o_sioc, 1);
    check("reset_siod", o_siod_out, 1);
    check("reset_oe", o_siod_oe, 1);
    check("reset_busy", o_busy, 0);
    check("reset_done", o_done, 0);
    check("reset_rd_data", o_rd_data, 0);
    i_rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_bus", {o_sioc, o_siod_out, o_siod_oe, o_busy}, 4'b1110);

    run_txn(1'b0, 7'h3C, 16'h3008, 8'h80, 8'h00, 1'b0, -1, "wr_spec");
    check("sioc_period", period_meas, SLOT);
    run_txn(1'b1, 7'h3C, 16'h300A, 8'h00, 8'hA5, 1'b0, -1, "rd_spec");
    run_txn(1'b0, 7'h21, 16'h1234, 8'h56, 8'h00, 1'b0, 20000 * QTR / 250, "wr_reset");
    r_id = 7'($urandom); r_addr = 16'($urandom); r_wd = 8'($urandom);
    run_txn(1'b0, r_id, r_addr, r_wd, 8'h00, 1'b0, -1, "wr_after_reset");
    for (int k = 0; k < 3; k++) begin
      r_rw = (k == 0) ? 1'b1 : 1'($urandom);
      r_id = 7'($urandom); r_addr = 16'($urandom); r_wd = 8'($urandom); r_sb = 8'($urandom);
      run_txn(r_rw, r_id, r_addr, r_wd, r_sb, 1'b1, -1, "rand_busy_start");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
